mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arbiter_rr_picker.sv | 30 +++
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared types and constants for the two-port memory arbiter.
//             It holds the FSM state enum, the port-id type, the default
//             widths, and a saturating-increment helper for the grant
//             counters.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int DEF_DATA_WIDTH    = 20;
  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int CNT_WIDTH         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_EXT = 1'b1
  } port_id_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker2
//  Purpose  : Two-way round-robin pick. When only one request is present,
//             that request wins. When both are present, the port that was
//             not granted last wins.
//  Ports    : req_i  [1:0] - request vector (bit0 = CPU, bit1 = EXT)
//             last_i       - port granted most recently
//             gnt_o  [1:0] - one-hot grant (all zero when no request)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_id_e   last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i == 2'b11) begin
      gnt_o = (last_i == PORT_CPU) ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Arbitrates a CPU port and an external (host loader) port onto
//             one synchronous memory. Each access takes three cycles:
//               IDLE  - a request is sampled, then latched
//               ISSUE - grant pulse, memory command driven
//               RESP  - done pulse, read data returned
//             Contention is resolved round-robin. After reset, the CPU is
//             favoured.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             cpu_* / ext_* inputs      - req, we, be, addr, wdata per port
//             cpu_gnt/ext_gnt           - one-cycle accept pulse
//             cpu_done/ext_done         - one-cycle completion pulse
//             cpu_rdata/ext_rdata       - read data (valid with done on read)
//             cpu_stall                 - cpu_req & ~cpu_done
//             mem_addr/wdata/we/be      - memory command
//             mem_rdata                 - memory read data (1-cycle latency)
//             cnt_cpu/cnt_ext           - saturating grant counters
//  Config   : MEM_ARBITER_COUNTERS_EN   - builds the grant counters; when it
//                                          is undefined, both counters are 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     ext_req,
  input  logic                     cpu_we,
  input  logic                     ext_we,
  input  logic                     cpu_be,
  input  logic                     ext_be,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [ADDRESS_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic [DATA_WIDTH-1:0]    ext_wdata,
  output logic                     cpu_gnt,
  output logic                     ext_gnt,
  output logic                     cpu_done,
  output logic                     ext_done,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic [DATA_WIDTH-1:0]    ext_rdata,
  output logic                     cpu_stall,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
  output logic                     mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [CNT_WIDTH-1:0]     cnt_cpu,
  output logic [CNT_WIDTH-1:0]     cnt_ext
);

  state_e                   state_q, state_d;
  // owner_q is both the id of the access in flight and the round-robin
  // "last granted" pointer, because both are updated at the same moment.
  port_id_e                 owner_q;
  logic                     we_q;
  logic                     be_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    cpu_rdata_q;
  logic [DATA_WIDTH-1:0]    ext_rdata_q;

  logic [1:0]               pick;
  port_id_e                 pick_id;
  logic                     latch_en;

  rr_picker2 u_picker (
    .req_i  ({ext_req, cpu_req}),
    .last_i (owner_q),
    .gnt_o  (pick)
  );

  assign pick_id = pick[1] ? PORT_EXT : PORT_CPU;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pick) begin
          state_d  = ISSUE;
          latch_en = 1'b1;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, latched request, and held read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= PORT_EXT;            // EXT "granted last", so CPU is favoured
      we_q        <= 1'b0;
      be_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        owner_q <= pick_id;
        if (pick_id == PORT_EXT) begin
          we_q    <= ext_we;
          be_q    <= ext_be;
          addr_q  <= ext_addr;
          wdata_q <= ext_wdata;
        end else begin
          we_q    <= cpu_we;
          be_q    <= cpu_be;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end
      end
      // Keep the returned word so the port's rdata holds after done.
      if (state_q == RESP && !we_q) begin
        if (owner_q == PORT_CPU) begin
          cpu_rdata_q <= mem_rdata;
        end else begin
          ext_rdata_q <= mem_rdata;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. These are gated by rst, so an access aborted in ISSUE or RESP
  // never shows a grant, a done, or a write strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    cpu_done  = 1'b0;
    ext_done  = 1'b0;
    mem_we    = 1'b0;
    cpu_rdata = cpu_rdata_q;
    ext_rdata = ext_rdata_q;
    if (!rst) begin
      case (state_q)
        ISSUE: begin
          mem_we = we_q;
          if (owner_q == PORT_CPU) begin
            cpu_gnt = 1'b1;
          end else begin
            ext_gnt = 1'b1;
          end
        end
        RESP: begin
          if (owner_q == PORT_CPU) begin
            cpu_done = 1'b1;
            if (!we_q) begin
              cpu_rdata = mem_rdata;
            end
          end else begin
            ext_done = 1'b1;
            if (!we_q) begin
              ext_rdata = mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The command registers simply hold between accesses.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign cpu_stall = cpu_req & ~cpu_done;

  // --------------------------------------------------------------------------
  // Optional grant counters
  // --------------------------------------------------------------------------
`ifdef MEM_ARBITER_COUNTERS_EN
  logic [CNT_WIDTH-1:0] cnt_cpu_q;
  logic [CNT_WIDTH-1:0] cnt_ext_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_cpu_q <= '0;
      cnt_ext_q <= '0;
    end else begin
      if (cpu_gnt) begin
        cnt_cpu_q <= sat_inc(cnt_cpu_q);
      end
      if (ext_gnt) begin
        cnt_ext_q <= sat_inc(cnt_ext_q);
      end
    end
  end

  assign cnt_cpu = cnt_cpu_q;
  assign cnt_ext = cnt_ext_q;
`else
  assign cnt_cpu = '0;
  assign cnt_ext = '0;
`endif

endmodule
`default_nettype wire
